// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animator block.
package sprite_pkg;

  // Animation states for the frame sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    JUMP = 2'd2
  } anim_state_t;

  // Default sprite geometry and frame strip layout.
  localparam int unsigned DEF_SPR_W      = 32;
  localparam int unsigned DEF_SPR_H      = 32;
  localparam int unsigned DEF_NUM_FRAMES = 4;
  localparam int unsigned DEF_FRAME_DIV  = 6;

  // Visible VGA raster.
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Smallest ROM address width that holds the whole frame strip.
  function automatic int unsigned min_addr_w(input int unsigned w, input int unsigned h,
                                             input int unsigned n);
    return $clog2(w * h * n);
  endfunction

endpackage

// File: rtl/sprite_frame_sequencer.sv
// Animation FSM for one character: picks stand/run/jump frames and latches the
// facing direction (and the optional vertical flip, SPRITE_VFLIP_EN) on frame_tick.
module sprite_frame_sequencer
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int unsigned FRAME_DIV  = DEF_FRAME_DIV
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          moving,
  input  logic                          jumping,
  input  logic                          is_right,
`ifdef SPRITE_VFLIP_EN
  input  logic                          flip_v,
  output logic                          flip_l,
`endif
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          dir_l
);

  localparam int unsigned FRAME_W    = $clog2(NUM_FRAMES);
  localparam int unsigned DIV_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int unsigned DIV_MAX    = FRAME_DIV - 1;
  localparam int unsigned LAST_RUN   = NUM_FRAMES - 2;
  localparam int unsigned JUMP_FRAME = NUM_FRAMES - 1;

  anim_state_t        r_state, w_state_n;
  logic [DIV_W-1:0]   r_div, w_div_n;
  // Current run-cycle frame; only meaningful while in RUN.
  logic [FRAME_W-1:0] r_run_frame, w_run_frame_n;
  logic               r_dir;
`ifdef SPRITE_VFLIP_EN
  logic               r_flip;
`endif

  // State register: FSM, divider, run frame and latched direction/flip.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_run_frame <= FRAME_W'(1);
      r_dir       <= 1'b1;
`ifdef SPRITE_VFLIP_EN
      r_flip      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_n;
      r_div       <= w_div_n;
      r_run_frame <= w_run_frame_n;
      if (frame_tick) begin
        r_dir  <= is_right;
`ifdef SPRITE_VFLIP_EN
        r_flip <= flip_v;
`endif
      end
    end
  end

  // Next-state logic: only a frame_tick moves the animation; jump beats run.
  always_comb begin
    w_state_n     = r_state;
    w_div_n       = r_div;
    w_run_frame_n = r_run_frame;
    if (frame_tick) begin
      unique case (r_state)
        IDLE: begin
          if (jumping) begin
            w_state_n = JUMP;
            w_div_n   = '0;
          end else if (moving) begin
            w_state_n     = RUN;
            w_div_n       = '0;
            w_run_frame_n = FRAME_W'(1);
          end
        end
        RUN: begin
          if (jumping) begin
            w_state_n = JUMP;
            w_div_n   = '0;
          end else if (!moving) begin
            w_state_n = IDLE;
            w_div_n   = '0;
          end else if (r_div == DIV_W'(DIV_MAX)) begin
            w_div_n       = '0;
            w_run_frame_n = (r_run_frame == FRAME_W'(LAST_RUN)) ? FRAME_W'(1)
                                                                 : r_run_frame + FRAME_W'(1);
          end else begin
            w_div_n = r_div + DIV_W'(1);
          end
        end
        JUMP: begin
          w_div_n = '0;
          if (!jumping) begin
            if (moving) begin
              w_state_n     = RUN;
              w_run_frame_n = FRAME_W'(1);
            end else begin
              w_state_n = IDLE;
            end
          end
        end
        default: begin
          w_state_n = IDLE;
          w_div_n   = '0;
        end
      endcase
    end
  end

  // Output decode: displayed frame follows directly from the state.
  always_comb begin
    frame_idx = '0;
    unique case (r_state)
      IDLE:    frame_idx = '0;
      RUN:     frame_idx = r_run_frame;
      JUMP:    frame_idx = FRAME_W'(JUMP_FRAME);
      default: frame_idx = '0;
    endcase
  end

  assign dir_l = r_dir;
`ifdef SPRITE_VFLIP_EN
  assign flip_l = r_flip;
`endif

endmodule

// File: rtl/sprite_animator.sv
// Per-character sprite renderer: hit test, frame-strip ROM addressing with
// horizontal mirroring and a two-stage output pipeline matching the ROM latency.
// Optional vertical flip input is enabled by defining SPRITE_VFLIP_EN.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W           = DEF_SPR_W,
  parameter int unsigned SPR_H           = DEF_SPR_H,
  parameter int unsigned NUM_FRAMES      = DEF_NUM_FRAMES,
  parameter int unsigned FRAME_DIV       = DEF_FRAME_DIV,
  parameter int unsigned IDX_W           = 3,
  parameter int unsigned TRANSPARENT_IDX = 0,
  parameter int unsigned ADDR_W          = 12
) (
  input  logic                          vga_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic                          blank,
  input  logic [9:0]                    SpriteX,
  input  logic [9:0]                    SpriteY,
  input  logic                          is_right,
  input  logic                          moving,
  input  logic                          jumping,
`ifdef SPRITE_VFLIP_EN
  input  logic                          flip_v,
`endif
  output logic [ADDR_W-1:0]             rom_address,
  input  logic [IDX_W-1:0]              rom_q,
  output logic [IDX_W-1:0]              pixel_idx,
  output logic                          sprite_on,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx
);

  localparam int unsigned FRAME_W = $clog2(NUM_FRAMES);

  logic [FRAME_W-1:0] w_frame_idx;
  logic               w_dir_l;
  logic               w_flip_l;

  sprite_frame_sequencer #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_seq (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .moving     (moving),
    .jumping    (jumping),
    .is_right   (is_right),
`ifdef SPRITE_VFLIP_EN
    .flip_v     (flip_v),
    .flip_l     (w_flip_l),
`endif
    .frame_idx  (w_frame_idx),
    .dir_l      (w_dir_l)
  );

`ifndef SPRITE_VFLIP_EN
  assign w_flip_l = 1'b0;
`endif

  assign frame_idx = w_frame_idx;

  // Hit test in 11 bits; the >= guards make the wrapped subtraction harmless,
  // so a sprite hanging off the right/bottom edge clips instead of wrapping.
  logic [10:0] w_col, w_row, w_col_eff, w_row_eff;
  logic        w_hit;

  assign w_col = {1'b0, DrawX} - {1'b0, SpriteX};
  assign w_row = {1'b0, DrawY} - {1'b0, SpriteY};
  assign w_hit = (DrawX >= SpriteX) && (w_col < 11'(SPR_W)) &&
                 (DrawY >= SpriteY) && (w_row < 11'(SPR_H));

  // Address generation: frame base + row offset + (possibly mirrored) column.
  always_comb begin
    w_col_eff   = w_dir_l  ? w_col : 11'(SPR_W - 1) - w_col;
    w_row_eff   = w_flip_l ? 11'(SPR_H - 1) - w_row : w_row;
    rom_address = ADDR_W'(w_frame_idx) * ADDR_W'(SPR_W * SPR_H)
                + ADDR_W'(w_row_eff) * ADDR_W'(SPR_W)
                + ADDR_W'(w_col_eff);
  end

  logic             r_hit_d, r_blank_d, r_sprite_on;
  logic [IDX_W-1:0] r_pixel_idx;
  logic             w_on;

  assign w_on = r_hit_d & r_blank_d & (rom_q != IDX_W'(TRANSPARENT_IDX));

  // Output pipeline: delay hit/blank to line up with ROM data, then register.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hit_d     <= 1'b0;
      r_blank_d   <= 1'b0;
      r_sprite_on <= 1'b0;
      r_pixel_idx <= '0;
    end else begin
      r_hit_d     <= w_hit;
      r_blank_d   <= blank;
      r_sprite_on <= w_on;
      r_pixel_idx <= w_on ? rom_q : '0;
    end
  end

  assign sprite_on = r_sprite_on;
  assign pixel_idx = r_pixel_idx;

endmodule

// File: tb/tb_sprite_animator.sv
// Self-checking bench for sprite_animator: directed scenarios followed by random
// scanning, compared against a behavioural model with an external ROM model.
module tb_sprite_animator;

  localparam int SW = 32;
  localparam int SH = 32;
  localparam int NF = 4;
  localparam int FD = 6;
  localparam int IW = 3;
  localparam int AW = 12;

  logic          vga_clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_tick = 1'b0;
  logic [9:0]    DrawX = '0, DrawY = '0, SpriteX = '0, SpriteY = '0;
  logic          blank = 1'b0, is_right = 1'b1, moving = 1'b0, jumping = 1'b0;
  logic          flip_v = 1'b0;
  logic [AW-1:0] rom_address;
  logic [IW-1:0] rom_q;
  logic [IW-1:0] pixel_idx;
  logic          sprite_on;
  logic [1:0]    frame_idx;

  always #5 vga_clk = ~vga_clk;

  sprite_animator #(
    .SPR_W (SW), .SPR_H (SH), .NUM_FRAMES (NF), .FRAME_DIV (FD),
    .IDX_W (IW), .TRANSPARENT_IDX (0), .ADDR_W (AW)
  ) dut (
    .vga_clk     (vga_clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .SpriteX     (SpriteX),
    .SpriteY     (SpriteY),
    .is_right    (is_right),
    .moving      (moving),
    .jumping     (jumping),
`ifdef SPRITE_VFLIP_EN
    .flip_v      (flip_v),
`endif
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pixel_idx   (pixel_idx),
    .sprite_on   (sprite_on),
    .frame_idx   (frame_idx)
  );

  // External synchronous frame-strip ROM.
  logic [IW-1:0] rom_mem [0:(1<<AW)-1];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 stand, 1 run, 2 jump; run frame derived from tick count.
  int m_mode = 0;
  int m_rt   = 0;
  int m_dir  = 1;
  int m_flip = 0;
  bit started = 0;

  // Values the next step applies to the DUT's slow inputs.
  int  n_sx = 0, n_sy = 0;
  logic n_right = 1'b1, n_mov = 1'b0, n_jmp = 1'b0, n_flip = 1'b0;

  typedef struct {
    logic [IW-1:0] idx;
    logic          on;
  } exp_t;
  exp_t q[$];

  function automatic int m_frame();
    if (m_mode == 1) return 1 + (m_rt / FD) % (NF - 2);
    if (m_mode == 2) return NF - 1;
    return 0;
  endfunction

  function automatic void m_tick(input logic mov, input logic jmp, input logic rgt,
                                 input logic flp);
    case (m_mode)
      0: if (jmp) m_mode = 2; else if (mov) begin m_mode = 1; m_rt = 0; end
      1: if (jmp) m_mode = 2; else if (!mov) m_mode = 0; else m_rt++;
      default: if (!jmp) begin
        if (mov) begin m_mode = 1; m_rt = 0; end else m_mode = 0;
      end
    endcase
    m_dir = int'(rgt);
`ifdef SPRITE_VFLIP_EN
    m_flip = int'(flp);
`else
    m_flip = 0 * int'(flp);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One pixel clock: check the pipeline, drive new inputs, predict results.
  task automatic step(input int dx, input int dy, input logic bl, input logic tk,
                      input logic rs);
    exp_t e;
    bit   hit;
    int   c, r, addr;
    @(negedge vga_clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("pixel_idx", 32'(pixel_idx), 32'(e.idx));
      chk("sprite_on", 32'(sprite_on), 32'(e.on));
    end
    if (started) chk("frame_idx", 32'(frame_idx), 32'(m_frame()));
    SpriteX = n_sx[9:0]; SpriteY = n_sy[9:0];
    is_right = n_right; moving = n_mov; jumping = n_jmp; flip_v = n_flip;
    DrawX = dx[9:0]; DrawY = dy[9:0]; blank = bl; frame_tick = tk; reset = rs;
    #1;
    hit  = dx >= n_sx && dx - n_sx < SW && dy >= n_sy && dy - n_sy < SH;
    c    = dx - n_sx;
    r    = dy - n_sy;
    if (m_flip != 0) r = SH - 1 - r;
    if (m_dir == 0) c = SW - 1 - c;
    addr = hit ? m_frame() * SW * SH + r * SW + c : 0;
    if (hit && !rs) chk("rom_address", 32'(rom_address), 32'(addr));
    if (rs) begin
      e.idx = '0; e.on = 1'b0;
      if (q.size() > 0) q[q.size()-1] = e;
      q.push_back(e);
      m_mode = 0; m_rt = 0; m_dir = 1; m_flip = 0;
      started = 1;
    end else begin
      e.on  = hit && bl && (rom_mem[addr] != 0);
      e.idx = e.on ? rom_mem[addr] : '0;
      q.push_back(e);
      if (tk) m_tick(n_mov, n_jmp, n_right, n_flip);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom_mem[i] = IW'($urandom);
    rom_mem[0]    = '0;
    rom_mem[31]   = 3'd5;
    rom_mem[1023] = 3'd6;

    // Reset, then basic scan at (100,200).
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    n_sx = 100; n_sy = 200;
    step(99, 210, 1, 0, 0);
    step(100, 200, 1, 0, 0);
    step(131, 231, 1, 0, 0);
    step(115, 215, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // Mirror via tick, then toggling is_right without a tick changes nothing.
    n_right = 1'b0;
    step(0, 0, 0, 1, 0);
    step(100, 200, 1, 0, 0);
    step(131, 200, 1, 0, 0);
    n_right = 1'b1;
    step(100, 200, 1, 0, 0);
    step(120, 210, 1, 0, 0);

    // Run cycle over 30 ticks.
    n_mov = 1'b1;
    for (int t = 0; t < 30; t++) begin
      step(0, 0, 0, 1, 0);
      step(100 + t, 200 + t, 1, 0, 0);
    end

    // Jump wins over run, then back to run, then idle.
    n_jmp = 1'b1;
    step(0, 0, 0, 1, 0);
    step(110, 205, 1, 0, 0);
    n_jmp = 1'b0;
    step(0, 0, 0, 1, 0);
    step(110, 205, 1, 0, 0);
    n_mov = 1'b0;
    step(0, 0, 0, 1, 0);
    step(100, 200, 1, 0, 0);

    // Transparent pixel, blank low, and right-edge clipping.
    step(100, 200, 1, 0, 0);
    step(131, 231, 0, 0, 0);
    n_sx = 620; n_sy = 200;
    for (int x = 600; x < 640; x++) step(x, 205, 1, 0, 0);
    for (int x = 0; x < 16; x++) step(x, 205, 1, 0, 0);

    // Reset while running at frame 2 mid-scan.
    n_sx = 100; n_sy = 200; n_mov = 1'b1;
    for (int i = 0; i < 20 && m_frame() != 2; i++) step(0, 0, 0, 1, 0);
    step(105, 205, 1, 0, 0);
    step(106, 205, 1, 0, 0);
    step(107, 205, 1, 0, 1);
    step(108, 205, 1, 0, 0);
    step(109, 205, 1, 0, 0);
    n_mov = 1'b0;

`ifdef SPRITE_VFLIP_EN
    n_flip = 1'b1;
    step(0, 0, 0, 1, 0);
    step(100, 200, 1, 0, 0);
    n_flip = 1'b0;
    step(0, 0, 0, 1, 0);
`endif

    // Random scanning with random animation inputs and ticks.
    for (int i = 0; i < 2500; i++) begin
      int dx, dy;
      if ($urandom_range(0, 99) == 0) begin
        n_sx = $urandom_range(0, 639);
        n_sy = $urandom_range(0, 479);
      end
      if ($urandom_range(0, 9) == 0) n_mov   = 1'($urandom);
      if ($urandom_range(0, 19) == 0) n_jmp  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) n_right = 1'($urandom);
      if ($urandom_range(0, 9) == 0) n_flip  = 1'($urandom);
      dx = n_sx + int'($urandom_range(0, 40)) - 4;
      dy = n_sy + int'($urandom_range(0, 40)) - 4;
      if (dx < 0) dx = 0;
      if (dy < 0) dy = 0;
      step(dx, dy, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 299) == 0));
    end

    // Drain the pipeline.
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
